// File: rtl/rom_arb_pkg.sv
// Shared constants, owner-tag encoding and frame-range helper for the pixel ROM arbiter.
package rom_arb_pkg;

  localparam int COORD_W      = 8;
  localparam int PIX_W        = 3;
  localparam int WIDTH_DEF    = 160;
  localparam int HEIGHT_DEF   = 120;
  localparam int MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  function automatic logic in_frame(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input int w,
                                    input int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/rom_arb_resp_pipe.sv
// Two-stage return path: owner tag travels alongside the ROM read, then the
// registered ROM data is steered into the owning port's output register.
module rom_arb_resp_pipe
  import rom_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  owner_t           acc_tag,
  input  logic             acc_oor,
  input  logic [PIX_W-1:0] rom_dout,
  output logic             p0_valid,
  output logic [PIX_W-1:0] p0_data,
  output logic             p1_valid,
  output logic [PIX_W-1:0] p1_data
);

  owner_t           tag_q;
  logic             oor_q;
  logic [PIX_W-1:0] pix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= OWN_NONE;
      oor_q <= 1'b0;
    end else begin
      tag_q <= acc_tag;
      oor_q <= acc_oor;
    end
  end

  // Out-of-frame reads still return a strobe, but with the pixel forced to 0.
  assign pix = oor_q ? '0 : rom_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_valid <= 1'b0;
      p1_valid <= 1'b0;
      p0_data  <= '0;
      p1_data  <= '0;
    end else begin
      p0_valid <= (tag_q == OWN_P0);
      p1_valid <= (tag_q == OWN_P1);
      if (tag_q == OWN_P0) p0_data <= pix;
      if (tag_q == OWN_P1) p1_data <= pix;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter for a shared registered pixel ROM: p0 has fixed priority,
// responses return at a fixed latency of 2. Define ROM_ARB_STARVE_GUARD_EN to
// let p1 win after MAX_WAIT consecutive denied cycles.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int HEIGHT   = HEIGHT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p0_req,
  input  logic [COORD_W-1:0] p0_x,
  input  logic [COORD_W-1:0] p0_y,
  input  logic               p1_req,
  input  logic [COORD_W-1:0] p1_x,
  input  logic [COORD_W-1:0] p1_y,
  output logic               p0_gnt,
  output logic               p1_gnt,
  output logic               p0_valid,
  output logic [PIX_W-1:0]   p0_data,
  output logic               p1_valid,
  output logic [PIX_W-1:0]   p1_data,
  output logic [COORD_W-1:0] rom_x,
  output logic [COORD_W-1:0] rom_y,
  input  logic [PIX_W-1:0]   rom_dout
);

  logic   force_p1;
  logic   p0_inr;
  logic   p1_inr;
  owner_t acc_tag;
  logic   acc_oor;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(MAX_WAIT + 1) < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign force_p1 = p1_req && (wait_cnt == CNT_W'(MAX_WAIT));

  // Counts denied p1 cycles; saturates so p1 keeps winning until it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!p1_req || p1_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_max_wait = MAX_WAIT;

  assign force_p1 = 1'b0;
`endif

  assign p0_inr = in_frame(p0_x, p0_y, WIDTH, HEIGHT);
  assign p1_inr = in_frame(p1_x, p1_y, WIDTH, HEIGHT);

  // Grants stay live during reset; the held-in-reset pipe keeps them from being accepted.
  always_comb begin
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    rom_x   = '0;
    rom_y   = '0;
    acc_tag = OWN_NONE;
    acc_oor = 1'b0;
    if (p1_req && (force_p1 || !p0_req)) begin
      p1_gnt  = 1'b1;
      acc_tag = OWN_P1;
      acc_oor = !p1_inr;
      if (p1_inr) begin
        rom_x = p1_x;
        rom_y = p1_y;
      end
    end else if (p0_req) begin
      p0_gnt  = 1'b1;
      acc_tag = OWN_P0;
      acc_oor = !p0_inr;
      if (p0_inr) begin
        rom_x = p0_x;
        rom_y = p0_y;
      end
    end
  end

  rom_arb_resp_pipe u_resp_pipe (
    .clk      (clk),
    .reset    (reset),
    .acc_tag  (acc_tag),
    .acc_oor  (acc_oor),
    .rom_dout (rom_dout),
    .p0_valid (p0_valid),
    .p0_data  (p0_data),
    .p1_valid (p1_valid),
    .p1_data  (p1_data)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: stimulus pushes expected responses, a
// negedge monitor pops and compares them against the valid strobes.
module tb_rom_arbiter;

  logic       clk;
  logic       reset;
  logic       p0_req, p1_req;
  logic [7:0] p0_x, p0_y, p1_x, p1_y;
  logic       p0_gnt, p1_gnt;
  logic       p0_valid, p1_valid;
  logic [2:0] p0_data, p1_data;
  logic [7:0] rom_x, rom_y;
  logic [2:0] rom_dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [2:0] data;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [2:0] last0 = 3'h0;
  logic [2:0] last1 = 3'h0;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  rom_arbiter #(.WIDTH(160), .HEIGHT(120), .MAX_WAIT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .p0_req   (p0_req),
    .p0_x     (p0_x),
    .p0_y     (p0_y),
    .p1_req   (p1_req),
    .p1_x     (p1_x),
    .p1_y     (p1_y),
    .p0_gnt   (p0_gnt),
    .p1_gnt   (p1_gnt),
    .p0_valid (p0_valid),
    .p0_data  (p0_data),
    .p1_valid (p1_valid),
    .p1_data  (p1_data),
    .rom_x    (rom_x),
    .rom_y    (rom_y),
    .rom_dout (rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel ROM model: f(5,3)=6, f(0,0)=6 so forced-zero out-of-range data is distinguishable.
  function automatic logic [2:0] rom_fn(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y} + 9'd6;
    return s[2:0];
  endfunction

  always @(posedge clk) begin
    rom_dout <= rom_fn(rom_x, rom_y);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [2:0] d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (p == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    if (p == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (have && e.cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL p%0d_missing_valid: no valid at cyc %0d, expected data %0d", p, e.cyc, e.data);
      if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      have = 1'b0;
    end
    if (v) begin
      if (!have || e.cyc != cyc) begin
        checks++;
        failures++;
        $display("FAIL p%0d_unexpected_valid @cyc %0d: got data %0d, expected no valid", p, cyc, d);
      end else begin
        check($sformatf("p%0d_data", p), d, e.data);
        if (p == 0) begin void'(q0.pop_front()); last0 = e.data; end
        else begin void'(q1.pop_front()); last1 = e.data; end
      end
    end else begin
      check($sformatf("p%0d_data_hold", p), d, (p == 0) ? last0 : last1);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("rst_p0_valid", p0_valid, 0);
      check("rst_p1_valid", p1_valid, 0);
      check("rst_p0_data", p0_data, 0);
      check("rst_p1_data", p1_data, 0);
      last0 = 3'h0;
      last1 = 3'h0;
    end else begin
      mon(0, p0_valid, p0_data);
      mon(1, p1_valid, p1_data);
    end
  end

  task automatic step(input logic r0, input logic [7:0] x0, input logic [7:0] y0,
                      input logic r1, input logic [7:0] x1, input logic [7:0] y1,
                      input logic eg0, input logic eg1);
    logic [7:0] ex, ey, ax, ay;
    logic       inr;
    exp_t       e;
    @(posedge clk);
    #1;
    p0_req = r0; p0_x = x0; p0_y = y0;
    p1_req = r1; p1_x = x1; p1_y = y1;
    #1;
    check("p0_gnt", p0_gnt, eg0);
    check("p1_gnt", p1_gnt, eg1);
    ax = eg1 ? x1 : x0;
    ay = eg1 ? y1 : y0;
    inr = (ax < 8'd160) && (ay < 8'd120);
    ex = ((eg0 || eg1) && inr) ? ax : 8'd0;
    ey = ((eg0 || eg1) && inr) ? ay : 8'd0;
    check("rom_x", rom_x, ex);
    check("rom_y", rom_y, ey);
    if (!reset && (eg0 || eg1)) begin
      e.cyc  = cyc + 2;
      e.data = inr ? rom_fn(ax, ay) : 3'h0;
      if (eg0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    p0_req = 0; p0_x = 0; p0_y = 0;
    p1_req = 0; p1_x = 0; p1_y = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // single p1 read at (5,3) -> data 6 two cycles later
    step(0, 0, 0, 1, 5, 3, 0, 1);
    idle(3);

    // both requesting continuously; with the guard p1 wins on its 9th waiting cycle
    for (int i = 0; i < 12; i++) begin
      logic g1;
      g1 = GUARD && (i == 8);
      step(1, 8'(i + 10), 8'(i), 1, 7, 7, !g1, g1);
    end
    idle(3);

    // out-of-range and boundary coordinates
    step(1, 160, 0, 0, 0, 0, 1, 0);
    step(1, 0, 120, 0, 0, 0, 1, 0);
    step(1, 159, 119, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 200, 255, 0, 1);
    idle(3);

    // alternating owners every cycle, then a contested cycle
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1, 8'(i + 1), 1, 0, 0, 0, 1, 0);
      else            step(0, 0, 0, 1, 8'(i + 1), 2, 0, 1);
    end
    step(1, 10, 20, 1, 30, 40, 1, 0);
    step(0, 0, 0, 1, 30, 40, 0, 1);
    idle(3);

    // accept p0 at N, reset in N+1: in-flight response dropped, grants still combinational
    step(1, 4, 4, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    q0.delete();
    q1.delete();
    step(1, 9, 9, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 3, 3, 0, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    p1_req = 0;
    idle(4);

    // recovery after reset
    step(1, 2, 2, 0, 0, 0, 1, 0);
    idle(5);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameters: WIDTH, 160, frame width in pixels; HEIGHT, 120, frame height in pixels; MAX_WAIT, 8, starvation limit in cycles for port 1.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: p0_req  input  1 and p1_req  input  1  read request from port 0 (display, priority) and port 1 (game logic).
REQ-005 SHALL have ports: p0_x, p1_x  input  8  pixel column; p0_y, p1_y  input  8  pixel row.
REQ-006 SHALL have ports: p0_gnt, p1_gnt  output  1  combinational grant, one-hot or zero.
REQ-007 SHALL have ports: p0_valid, p1_valid  output  1  one-cycle response strobe; p0_data, p1_data  output  3  pixel value.
REQ-008 SHALL have ports: rom_x  output  8 and rom_y  output  8  to the shared pixel ROM; rom_dout  input  3  ROM data, registered inside the ROM, one cycle after the address.

Function
REQ-009 SHALL accept a request in cycle N when pX_req and pX_gnt are both high at the rising edge ending N.
REQ-010 SHALL grant at most one port per cycle; default policy is fixed priority: p0 wins whenever p0_req is high.
REQ-011 SHALL drive rom_x/rom_y combinationally from the granted port in the grant cycle; with no grant, rom_x = rom_y = 0.
REQ-012 SHALL capture rom_dout at the edge ending cycle N+1 and assert the owner's pX_valid for exactly cycle N+2, with pX_data holding the value; fixed latency 2.
REQ-013 SHALL sustain one accepted request per cycle (fully pipelined); back-to-back and alternating owners SHALL return in request order.
REQ-014 SHALL treat x >= WIDTH or y >= HEIGHT as out of range: request granted and accepted, ROM driven with 0/0, response data forced to 3'h0, valid still asserted.
REQ-015 SHALL hold pX_data at its last value while pX_valid is low.
REQ-016 SHALL NOT issue a grant to a port whose req is low; a request withdrawn before acceptance SHALL produce no response.

Reset
REQ-017 SHALL, while reset is high, force p0_valid = p1_valid = 0, p0_data = p1_data = 0, all pipeline tags empty, and the wait counter to 0.
REQ-018 SHALL drop in-flight responses when reset asserts mid-operation; no valid SHALL appear after reset deasserts for requests accepted before it.
REQ-019 Grants SHALL remain combinational during reset but no request SHALL be accepted while reset is high.

Configuration
REQ-020 SHALL, when ROM_ARB_STARVE_GUARD_EN is defined, count consecutive cycles with p1_req high and p1 not granted; when the count equals MAX_WAIT, p1 SHALL win that cycle over p0.
REQ-021 SHALL clear the counter on p1 acceptance or when p1_req is low; the counter SHALL saturate at MAX_WAIT.
REQ-022 SHALL, when ROM_ARB_STARVE_GUARD_EN is undefined, use strict p0 priority with no counter logic present.

Structure
REQ-023 SHALL place COORD_W=8, PIX_W=3, WIDTH, HEIGHT, MAX_WAIT defaults and the owner-tag encoding (NONE, P0, P1) in package rom_arb_pkg.
REQ-024 SHALL implement the 2-stage tag/valid/data return path as sub-module rom_arb_resp_pipe.

Verification
REQ-025 Single p1 read at (5,3), ROM model returns 3'h6 -> p1_gnt same cycle, p1_valid exactly 2 cycles later with p1_data = 3'h6.
REQ-026 p0 and p1 both requesting continuously, guard off -> p1_gnt never asserts; p0 gets 1 result per cycle, in order.
REQ-027 Same stimulus, ROM_ARB_STARVE_GUARD_EN, MAX_WAIT=8 -> p1 granted on the 9th cycle of waiting, then counter = 0 and p0 resumes.
REQ-028 p0 read at (160,0) then (0,120) -> both granted, rom_x = rom_y = 0, two p0_valid strobes with p0_data = 3'h0.
REQ-029 Accept p0 at cycle N, assert reset in cycle N+1 -> no p0_valid at N+2 or later; all outputs 0 during reset.
REQ-030 Alternating p0/p1 accepts every cycle -> valids alternate at 2-cycle latency, each port's data matches its own address.
